// File: rtl/wts_channel_register.sv
// wts_channel_register
// Host register block for the wave table sound core. Decodes windowed host
// accesses into per-channel frequency/volume/enable registers and a mode
// register, and forwards wave RAM accesses to the wave SRAM through a
// request/acknowledge FSM with a one-deep pending slot. Channel parameters
// are looked up by channel index for the time-multiplexed tone generator.
module wts_channel_register #(
   parameter int CHANNELS = 5,
   parameter int FREQ_W   = 12,
   parameter int VOL_W    = 4,
   parameter int IDX_W    = 3
) (
   input  logic                nreset,
   input  logic                clk,
   input  logic                wrreq,
   input  logic                rdreq,
   input  logic [8:0]          address,
   input  logic [7:0]          wrdata,
   output logic [7:0]          rddata,
   output logic                rdvalid,
   output logic                busy,
   output logic                overrun,
   output logic                sram_req,
   output logic                sram_we,
   output logic [IDX_W-1:0]    sram_id,
   output logic [4:0]          sram_a,
   output logic [7:0]          sram_d,
   input  logic                sram_ack,
   input  logic [7:0]          sram_q,
   input  logic [IDX_W-1:0]    ch_index,
   output logic [FREQ_W-1:0]   ch_freq,
   output logic [VOL_W-1:0]    ch_vol,
   output logic                ch_enable,
   output logic [CHANNELS-1:0] clear_counter,
   output logic                wave_reset
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } wave_state_t;

   // Channel count as a 4-bit value so the 3-bit wave channel field compares cleanly.
   localparam logic [3:0] CHAN_LIMIT = 4'(CHANNELS);

   // Channel register file
   logic [FREQ_W-1:0]   freq_q   [CHANNELS];
   logic [FREQ_W-1:0]   freq_d   [CHANNELS];
   logic [7:0]          shadow_q [CHANNELS];
   logic [7:0]          shadow_d [CHANNELS];
   logic [VOL_W-1:0]    vol_q    [CHANNELS];
   logic [VOL_W-1:0]    vol_d    [CHANNELS];
   logic [CHANNELS-1:0] enable_q, enable_d;
   logic [CHANNELS-1:0] clear_q, clear_d;
   logic                wave_reset_q, wave_reset_d;

   // Register read path
   logic                reg_rdvalid_q, reg_rdvalid_d;
   logic [7:0]          reg_rddata_q, reg_rddata_d;

   // Tone pipeline lookup
   logic [FREQ_W-1:0]   ch_freq_q, ch_freq_d;
   logic [VOL_W-1:0]    ch_vol_q, ch_vol_d;
   logic                ch_enable_q, ch_enable_d;

   // Wave FSM, in-flight transaction and pending slot
   wave_state_t         state_q, state_d;
   logic                txn_we_q, txn_we_d;
   logic [IDX_W-1:0]    txn_id_q, txn_id_d;
   logic [4:0]          txn_a_q, txn_a_d;
   logic [7:0]          txn_d_q, txn_d_d;
   logic                pend_valid_q, pend_valid_d;
   logic                pend_we_q, pend_we_d;
   logic [IDX_W-1:0]    pend_id_q, pend_id_d;
   logic [4:0]          pend_a_q, pend_a_d;
   logic [7:0]          pend_d_q, pend_d_d;
   logic [7:0]          wave_data_q, wave_data_d;
   logic                overrun_q, overrun_d;

   // Access decode
   logic                wr_en;
   logic                rd_en;
   logic                is_wave;
   logic                wave_ch_ok;
   logic                wave_acc;
   logic [7:0]          reg_off;
   logic [7:0]          rd_value;

   // Classify the host access; a simultaneous write suppresses the read.
   always_comb begin
      wr_en      = wrreq;
      rd_en      = rdreq & ~wrreq;
      is_wave    = ~address[8];
      wave_ch_ok = ({1'b0, address[7:5]} < CHAN_LIMIT);
      wave_acc   = (wr_en | rd_en) & is_wave & wave_ch_ok;
      reg_off    = address[7:0];
   end

   // Register writes, read-data mux and phase-reset pulses.
   always_comb begin
      freq_d         = freq_q;
      shadow_d       = shadow_q;
      vol_d          = vol_q;
      enable_d       = enable_q;
      wave_reset_d   = wave_reset_q;
      clear_d        = '0;
      rd_value       = 8'hFF;
      if (!is_wave) begin
         for (int k = 0; k < CHANNELS; k++) begin
            if (reg_off == 8'(2 * k)) begin
               rd_value = freq_q[k][7:0];
               if (wr_en) begin
                  // Low byte waits in the shadow until the high byte commits both.
                  shadow_d[k] = wrdata;
                  clear_d[k]  = 1'b1;
               end
            end
            if (reg_off == 8'(2 * k + 1)) begin
               rd_value = 8'(freq_q[k][FREQ_W-1:8]);
               if (wr_en) begin
                  freq_d[k]  = {wrdata[FREQ_W-9:0], shadow_q[k]};
                  clear_d[k] = 1'b1;
               end
            end
            if (reg_off == 8'(16 + k)) begin
               rd_value = 8'(vol_q[k]);
               if (wr_en) begin
                  vol_d[k] = wrdata[VOL_W-1:0];
               end
            end
         end
         if (reg_off == 8'h18) begin
            rd_value = 8'(enable_q);
            if (wr_en) begin
               enable_d = wrdata[CHANNELS-1:0];
            end
         end
         if (reg_off == 8'h19) begin
            rd_value = {2'b00, wave_reset_q, 5'b00000};
            if (wr_en) begin
               wave_reset_d = wrdata[5];
            end
         end
      end
      // Wave accesses to absent channels are answered here with 0xFF.
      reg_rdvalid_d = rd_en & (~is_wave | ~wave_ch_ok);
      reg_rddata_d  = reg_rdvalid_d ? rd_value : 8'h00;
   end

   // Channel lookup uses next-state values so a write at T is seen from T+1.
   always_comb begin
      ch_freq_d   = '0;
      ch_vol_d    = '0;
      ch_enable_d = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (ch_index == IDX_W'(k)) begin
            ch_freq_d   = freq_d[k];
            ch_vol_d    = vol_d[k];
            ch_enable_d = enable_d[k];
         end
      end
   end

   // Wave FSM next state, transaction launch and pending-slot management.
   always_comb begin
      state_d      = state_q;
      txn_we_d     = txn_we_q;
      txn_id_d     = txn_id_q;
      txn_a_d      = txn_a_q;
      txn_d_d      = txn_d_q;
      pend_valid_d = pend_valid_q;
      pend_we_d    = pend_we_q;
      pend_id_d    = pend_id_q;
      pend_a_d     = pend_a_q;
      pend_d_d     = pend_d_q;
      wave_data_d  = wave_data_q;
      overrun_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pend_valid_q) begin
               state_d      = ST_REQ;
               txn_we_d     = pend_we_q;
               txn_id_d     = pend_id_q;
               txn_a_d      = pend_a_q;
               txn_d_d      = pend_d_q;
               pend_valid_d = 1'b0;
            end else if (wave_acc) begin
               state_d  = ST_REQ;
               txn_we_d = wr_en;
               txn_id_d = IDX_W'(address[7:5]);
               txn_a_d  = address[4:0];
               txn_d_d  = wrdata;
            end
         end
         ST_REQ: begin
            if (sram_ack) begin
               if (txn_we_q) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d     = ST_RESP;
                  wave_data_d = sram_q;
               end
            end
         end
         ST_RESP: begin
            // A register read result owns this cycle; hold the wave result.
            if (!reg_rdvalid_q) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Wave access that cannot launch directly: park it or drop it.
      if (wave_acc && !(state_q == ST_IDLE && !pend_valid_q)) begin
         if (state_q == ST_IDLE || !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_we_d    = wr_en;
            pend_id_d    = IDX_W'(address[7:5]);
            pend_a_d     = address[4:0];
            pend_d_d     = wrdata;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // Wave FSM state register.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Host-visible outputs; register read results take priority over wave data.
   always_comb begin
      sram_req      = (state_q == ST_REQ);
      sram_we       = txn_we_q;
      sram_id       = txn_id_q;
      sram_a        = txn_a_q;
      sram_d        = txn_d_q;
      rdvalid       = reg_rdvalid_q | (state_q == ST_RESP);
      rddata        = reg_rdvalid_q ? reg_rddata_q :
                      ((state_q == ST_RESP) ? wave_data_q : 8'h00);
      busy          = (state_q != ST_IDLE) | pend_valid_q;
      overrun       = overrun_q;
      clear_counter = clear_q;
      wave_reset    = wave_reset_q;
      ch_freq       = ch_freq_q;
      ch_vol        = ch_vol_q;
      ch_enable     = ch_enable_q;
   end

   // All remaining storage: channel registers, read path, lookup, wave datapath.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int k = 0; k < CHANNELS; k++) begin
            freq_q[k]   <= '0;
            shadow_q[k] <= '0;
            vol_q[k]    <= '0;
         end
         enable_q      <= '0;
         clear_q       <= '0;
         wave_reset_q  <= 1'b0;
         reg_rdvalid_q <= 1'b0;
         reg_rddata_q  <= 8'h00;
         ch_freq_q     <= '0;
         ch_vol_q      <= '0;
         ch_enable_q   <= 1'b0;
         txn_we_q      <= 1'b0;
         txn_id_q      <= '0;
         txn_a_q       <= '0;
         txn_d_q       <= '0;
         pend_valid_q  <= 1'b0;
         pend_we_q     <= 1'b0;
         pend_id_q     <= '0;
         pend_a_q      <= '0;
         pend_d_q      <= '0;
         wave_data_q   <= '0;
         overrun_q     <= 1'b0;
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            freq_q[k]   <= freq_d[k];
            shadow_q[k] <= shadow_d[k];
            vol_q[k]    <= vol_d[k];
         end
         enable_q      <= enable_d;
         clear_q       <= clear_d;
         wave_reset_q  <= wave_reset_d;
         reg_rdvalid_q <= reg_rdvalid_d;
         reg_rddata_q  <= reg_rddata_d;
         ch_freq_q     <= ch_freq_d;
         ch_vol_q      <= ch_vol_d;
         ch_enable_q   <= ch_enable_d;
         txn_we_q      <= txn_we_d;
         txn_id_q      <= txn_id_d;
         txn_a_q       <= txn_a_d;
         txn_d_q       <= txn_d_d;
         pend_valid_q  <= pend_valid_d;
         pend_we_q     <= pend_we_d;
         pend_id_q     <= pend_id_d;
         pend_a_q      <= pend_a_d;
         pend_d_q      <= pend_d_d;
         wave_data_q   <= wave_data_d;
         overrun_q     <= overrun_d;
      end
   end

endmodule

// File: tb/tb_wts_channel_register.sv
// Testbench for wts_channel_register: table-driven register vectors plus
// hand-written wave-port sequences against a small SRAM responder model.
module tb_wts_channel_register;

   localparam int CHANNELS = 5;
   localparam int FREQ_W   = 12;
   localparam int VOL_W    = 4;
   localparam int IDX_W    = 3;

   logic                nreset;
   logic                clk;
   logic                wrreq;
   logic                rdreq;
   logic [8:0]          address;
   logic [7:0]          wrdata;
   logic [7:0]          rddata;
   logic                rdvalid;
   logic                busy;
   logic                overrun;
   logic                sram_req;
   logic                sram_we;
   logic [IDX_W-1:0]    sram_id;
   logic [4:0]          sram_a;
   logic [7:0]          sram_d;
   logic                sram_ack;
   logic [7:0]          sram_q;
   logic [IDX_W-1:0]    ch_index;
   logic [FREQ_W-1:0]   ch_freq;
   logic [VOL_W-1:0]    ch_vol;
   logic                ch_enable;
   logic [CHANNELS-1:0] clear_counter;
   logic                wave_reset;

   int checks = 0;
   int errors = 0;

   wts_channel_register #(
      .CHANNELS(CHANNELS), .FREQ_W(FREQ_W), .VOL_W(VOL_W), .IDX_W(IDX_W)
   ) dut (
      .nreset(nreset), .clk(clk), .wrreq(wrreq), .rdreq(rdreq),
      .address(address), .wrdata(wrdata), .rddata(rddata), .rdvalid(rdvalid),
      .busy(busy), .overrun(overrun), .sram_req(sram_req), .sram_we(sram_we),
      .sram_id(sram_id), .sram_a(sram_a), .sram_d(sram_d), .sram_ack(sram_ack),
      .sram_q(sram_q), .ch_index(ch_index), .ch_freq(ch_freq), .ch_vol(ch_vol),
      .ch_enable(ch_enable), .clear_counter(clear_counter), .wave_reset(wave_reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM responder: ack once sram_req has been high for ack_delay cycles.
   int         ack_delay = 3;
   int         req_cnt   = 0;
   logic [7:0] mem [256];

   initial begin
      sram_ack = 1'b0;
      sram_q   = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (sram_ack) begin
            sram_ack = 1'b0;
            req_cnt  = 0;
         end else if (sram_req) begin
            req_cnt++;
            if (req_cnt >= ack_delay) begin
               sram_ack = 1'b1;
               if (sram_we) mem[{sram_id, sram_a}] = sram_d;
               else         sram_q = mem[{sram_id, sram_a}];
            end
         end else begin
            req_cnt = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end else begin
         $display("ok   %s = 0x%0h", name, act);
      end
   endtask

   task automatic reg_read(input string name, input logic [8:0] a, input logic [7:0] exp);
      rdreq   = 1'b1;
      address = a;
      step();
      rdreq = 1'b0;
      chk({name, "_rdvalid"}, 32'(rdvalid), 32'd1);
      chk({name, "_rddata"}, 32'(rddata), 32'(exp));
   endtask

   task automatic wait_rdvalid(input int max_cycles, output int n, output logic [7:0] d);
      n = 0;
      d = 8'h00;
      while (!rdvalid && n < max_cycles) begin
         step();
         n++;
      end
      if (rdvalid) d = rddata;
      else         n = -1;
   endtask

   typedef struct {
      logic       wr;
      logic       rd;
      logic [8:0] addr;
      logic [7:0] wdata;
      logic       exp_rv;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic wr, input logic rd, input logic [8:0] a,
                               input logic [7:0] wd, input logic rv, input logic [7:0] rdv);
      vec_t v;
      v.wr = wr; v.rd = rd; v.addr = a; v.wdata = wd; v.exp_rv = rv; v.exp_rd = rdv;
      return v;
   endfunction

   initial begin
      int          n;
      int          pulses;
      int          rises;
      int          req_cycles;
      logic        prev_req;
      logic [7:0]  d;
      logic [7:0]  got [$];

      // Reset-value reads across the whole register map (5 channels present).
      for (int a = 'h100; a <= 'h119; a++) begin
         logic [7:0] off;
         logic [7:0] e;
         off = 8'(a - 'h100);
         if (off < 8'h10)      e = ((off >> 1) < 8'd5) ? 8'h00 : 8'hFF;
         else if (off < 8'h18) e = ((off - 8'h10) < 8'd5) ? 8'h00 : 8'hFF;
         else                  e = 8'h00;
         vecs.push_back(mk(1'b0, 1'b1, 9'(a), 8'h00, 1'b1, e));
      end
      vecs.push_back(mk(1'b1, 1'b0, 9'h111, 8'h0B, 1'b0, 8'h00));
      vecs.push_back(mk(1'b0, 1'b1, 9'h111, 8'h00, 1'b1, 8'h0B));
      vecs.push_back(mk(1'b1, 1'b0, 9'h118, 8'h15, 1'b0, 8'h00));
      vecs.push_back(mk(1'b0, 1'b1, 9'h118, 8'h00, 1'b1, 8'h15));
      vecs.push_back(mk(1'b1, 1'b0, 9'h119, 8'hFF, 1'b0, 8'h00));
      vecs.push_back(mk(1'b0, 1'b1, 9'h119, 8'h00, 1'b1, 8'h20));
      vecs.push_back(mk(1'b1, 1'b0, 9'h116, 8'h03, 1'b0, 8'h00));
      vecs.push_back(mk(1'b0, 1'b1, 9'h116, 8'h00, 1'b1, 8'hFF));
      vecs.push_back(mk(1'b0, 1'b1, 9'h1A0, 8'h00, 1'b1, 8'hFF));
      vecs.push_back(mk(1'b0, 1'b1, 9'h0E0, 8'h00, 1'b1, 8'hFF));
      vecs.push_back(mk(1'b1, 1'b0, 9'h0E0, 8'h55, 1'b0, 8'h00));
      vecs.push_back(mk(1'b1, 1'b0, 9'h103, 8'h9F, 1'b0, 8'h00));
      vecs.push_back(mk(1'b0, 1'b1, 9'h103, 8'h00, 1'b1, 8'h0F));
      vecs.push_back(mk(1'b0, 1'b1, 9'h102, 8'h00, 1'b1, 8'h00));
      vecs.push_back(mk(1'b1, 1'b1, 9'h112, 8'h07, 1'b0, 8'h00));
      vecs.push_back(mk(1'b0, 1'b1, 9'h112, 8'h00, 1'b1, 8'h07));

      nreset   = 1'b0;
      wrreq    = 1'b0;
      rdreq    = 1'b0;
      address  = 9'h000;
      wrdata   = 8'h00;
      ch_index = '0;
      step();
      step();
      chk("rst_sram_req", 32'(sram_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdvalid", 32'(rdvalid), 32'd0);
      chk("rst_rddata", 32'(rddata), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_clear", 32'(clear_counter), 32'd0);
      chk("rst_ch_freq", 32'(ch_freq), 32'd0);
      chk("rst_wave_reset", 32'(wave_reset), 32'd0);
      nreset = 1'b1;
      step();

      foreach (vecs[i]) begin
         wrreq   = vecs[i].wr;
         rdreq   = vecs[i].rd;
         address = vecs[i].addr;
         wrdata  = vecs[i].wdata;
         step();
         wrreq = 1'b0;
         rdreq = 1'b0;
         chk($sformatf("vec%0d_a%03h_rdvalid", i, vecs[i].addr), 32'(rdvalid), 32'(vecs[i].exp_rv));
         if (vecs[i].exp_rv)
            chk($sformatf("vec%0d_a%03h_rddata", i, vecs[i].addr), 32'(rddata), 32'(vecs[i].exp_rd));
      end
      chk("wave_ch7_write_not_busy", 32'(busy), 32'd0);

      // Channel lookups for values set by the table.
      ch_index = 3'd1;
      step();
      chk("lk1_freq", 32'(ch_freq), 32'h0F00);
      chk("lk1_vol", 32'(ch_vol), 32'hB);
      chk("lk1_en", 32'(ch_enable), 32'd0);
      ch_index = 3'd2;
      step();
      chk("lk2_vol", 32'(ch_vol), 32'h7);
      chk("lk2_en", 32'(ch_enable), 32'd1);
      ch_index = 3'd6;
      step();
      chk("lk6_freq", 32'(ch_freq), 32'd0);
      chk("lk6_vol", 32'(ch_vol), 32'd0);
      chk("lk6_en", 32'(ch_enable), 32'd0);
      chk("wave_reset_set", 32'(wave_reset), 32'd1);

      // Atomic frequency update on channel 0.
      ch_index = 3'd0;
      wrreq = 1'b1; address = 9'h100; wrdata = 8'h34;
      step();
      wrreq = 1'b0;
      chk("flo_clear", 32'(clear_counter), 32'h01);
      chk("flo_freq_unchanged", 32'(ch_freq), 32'h000);
      step();
      chk("flo_clear_gone", 32'(clear_counter), 32'h00);
      wrreq = 1'b1; address = 9'h101; wrdata = 8'h12;
      step();
      wrreq = 1'b0;
      chk("fhi_clear", 32'(clear_counter), 32'h01);
      chk("fhi_freq", 32'(ch_freq), 32'h234);
      reg_read("f0_lo", 9'h100, 8'h34);
      reg_read("f0_hi", 9'h101, 8'h02);

      // Wave write 0x045 = 0xA5 with ack after 3 cycles.
      ack_delay = 3;
      wrreq = 1'b1; address = 9'h045; wrdata = 8'hA5;
      step();
      wrreq = 1'b0;
      chk("ww_req", 32'(sram_req), 32'd1);
      chk("ww_we", 32'(sram_we), 32'd1);
      chk("ww_id", 32'(sram_id), 32'd2);
      chk("ww_a", 32'(sram_a), 32'd5);
      chk("ww_d", 32'(sram_d), 32'hA5);
      chk("ww_busy", 32'(busy), 32'd1);
      req_cycles = 1;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (sram_req) req_cycles++;
         if (rdvalid) pulses++;
      end
      chk("ww_req_cycles", 32'(req_cycles), 32'd3);
      chk("ww_no_rdvalid", 32'(pulses), 32'd0);
      chk("ww_idle", 32'(busy), 32'd0);

      // Read it back: rdvalid one cycle after the ack cycle.
      rdreq = 1'b1; address = 9'h045;
      step();
      rdreq = 1'b0;
      chk("wr_we", 32'(sram_we), 32'd0);
      wait_rdvalid(20, n, d);
      chk("wr_latency", 32'(n), 32'd3);
      chk("wr_data", 32'(d), 32'hA5);
      chk("wr_req_dropped", 32'(sram_req), 32'd0);
      step();
      chk("wr_single_pulse", 32'(rdvalid), 32'd0);

      // Three back-to-back reads, slow ack: one queued, one dropped.
      mem[8'h21] = 8'h11;
      mem[8'h22] = 8'h22;
      mem[8'h23] = 8'h33;
      ack_delay = 5;
      rdreq = 1'b1; address = 9'h021;
      step();
      address = 9'h022;
      step();
      address = 9'h023;
      step();
      rdreq = 1'b0;
      chk("ov_pulse", 32'(overrun), 32'd1);
      chk("ov_busy", 32'(busy), 32'd1);
      step();
      chk("ov_pulse_end", 32'(overrun), 32'd0);
      got.delete();
      rises = 0;
      prev_req = sram_req;
      for (int c = 0; c < 40; c++) begin
         step();
         if (rdvalid) got.push_back(rddata);
         if (sram_req && !prev_req) rises++;
         prev_req = sram_req;
      end
      chk("ov_pulses", 32'(got.size()), 32'd2);
      if (got.size() >= 2) begin
         chk("ov_first", 32'(got[0]), 32'h11);
         chk("ov_second", 32'(got[1]), 32'h22);
      end
      chk("ov_second_launch", 32'(rises), 32'd1);
      chk("ov_idle", 32'(busy), 32'd0);

      // Register read landing in the wave response cycle wins it.
      ack_delay = 3;
      rdreq = 1'b1; address = 9'h045;
      step();
      rdreq = 1'b0;
      step();
      step();
      rdreq = 1'b1; address = 9'h118;
      step();
      rdreq = 1'b0;
      chk("col_reg_valid", 32'(rdvalid), 32'd1);
      chk("col_reg_data", 32'(rddata), 32'h15);
      step();
      chk("col_wave_valid", 32'(rdvalid), 32'd1);
      chk("col_wave_data", 32'(rddata), 32'hA5);
      step();
      chk("col_done", 32'(rdvalid), 32'd0);

      // Reset in the middle of a transaction with a pending access.
      ack_delay = 10;
      rdreq = 1'b1; address = 9'h045;
      step();
      address = 9'h046;
      step();
      rdreq = 1'b0;
      chk("mr_req_before", 32'(sram_req), 32'd1);
      #2;
      nreset = 1'b0;
      #1;
      chk("mr_req_async_drop", 32'(sram_req), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);
      step();
      step();
      nreset = 1'b1;
      pulses = 0;
      req_cycles = 0;
      for (int c = 0; c < 15; c++) begin
         step();
         if (rdvalid) pulses++;
         if (sram_req || busy) req_cycles++;
      end
      chk("mr_no_rdvalid", 32'(pulses), 32'd0);
      chk("mr_no_pending", 32'(req_cycles), 32'd0);
      chk("mr_wave_reset", 32'(wave_reset), 32'd0);
      reg_read("mr_enable", 9'h118, 8'h00);
      reg_read("mr_vol1", 9'h111, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wts_channel_register.md
# wts_channel_register

Parametrised SCC-family register block for the wave table sound core: decodes an already-windowed host access into per-channel frequency/volume/enable registers, a mode register, and a wave-memory port with request/acknowledge handshake and a one-deep pending slot. Channel parameters are presented to the time-multiplexed tone generator through a registered channel-index lookup. Sits between the cartridge bank/mode decoder and the wave SRAM and tone/mixer pipeline.

## Interface
- CHANNELS, 5, number of channels, 1..8
- FREQ_W, 12, frequency counter width, 9..16
- VOL_W, 4, volume width, 1..8
- IDX_W, 3, width of channel index fields; must be at least clog2(CHANNELS)

Ports:
- nreset  in  1  reset, asynchronous, active-low
- clk  in  1  clock
- wrreq  in  1  one-cycle write strobe
- rdreq  in  1  one-cycle read strobe
- address  in  9  offset in window
- wrdata  in  8  write data
- rddata  out  8  read data
- rdvalid  out  1  one-cycle read-data-valid pulse
- busy  out  1  wave transaction in flight
- overrun  out  1  one-cycle pulse when a wave access is dropped
- sram_req  out  1  wave memory request, held until ack
- sram_we  out  1  request is a write
- sram_id  out  IDX_W  channel
- sram_a  out  5  sample index
- sram_d  out  8  write data
- sram_ack  in  1  one-cycle acknowledge; sram_q valid same cycle
- sram_q  in  8  read data
- ch_index  in  IDX_W  channel queried by tone pipeline
- ch_freq  out  FREQ_W  frequency of ch_index
- ch_vol  out  VOL_W  volume of ch_index
- ch_enable  out  1  enable of ch_index
- clear_counter  out  CHANNELS  one-hot phase-reset pulse
- wave_reset  out  1  mode bit 5

## Operation
- Map: 0x000-0x0FF wave RAM, channel=address[7:5], sample=address[4:0]. 0x100+2k / 0x101+2k: frequency low / high byte of channel k. 0x110+k: volume (wrdata[VOL_W-1:0]). 0x118: enable mask, bit k = channel k. 0x119: mode, bit 5 = wave_reset, other bits read 0.
- Frequency high byte supplies bits FREQ_W-1:8 from wrdata LSBs. Low byte writes go to a per-channel shadow; committed together with the high byte on the high-byte write (atomic update). Reading the low byte returns the committed value.
- Any frequency byte write to channel k pulses clear_counter[k].
- Channel k >= CHANNELS, or unmapped address: writes ignored, reads return 0xFF with rdvalid.
- wrreq and rdreq together: write executes, read ignored.
- Wave FSM: IDLE -> REQ (sram_req=1, id/a/d/we stable) -> on sram_ack: read -> RESP, write -> IDLE. RESP: drive rddata=captured sram_q with rdvalid, -> IDLE. Write FSM never pulses rdvalid.
- Wave access while not IDLE: stored in pending slot if empty; if full, dropped and overrun pulses. Pending slot launches from IDLE next cycle.
- Register accesses always served, even when busy.
- ch_index >= CHANNELS: ch_freq, ch_vol, ch_enable return 0.

## Timing
- Reset: every register, shadow, rddata, pending slot clear to 0; FSM IDLE; all outputs 0. Asynchronous assertion drops sram_req immediately; reset mid-transaction abandons it (no rdvalid).
- Register write at edge T: value visible on ch_* lookups from T+1; clear_counter pulse during cycle T+1 only.
- Register read at T: rddata/rdvalid at T+1.
- Wave access at T from IDLE: sram_req high from T+1; ack at cycle A: sram_req low from A+1; read data/rdvalid at A+1.
- Collision: register read result due same cycle as wave read result -> register wins; wave result stays in RESP, delivered next cycle.
- sram_req low at least one cycle between consecutive transactions; pending access issues sram_req at A+2 earliest.
- busy = FSM not IDLE or pending slot occupied.
- ch_* outputs registered: latency 1 from ch_index.

## Test plan
- Reset, then read 0x100..0x119 -> all 0x00 (0xFF above channel count), all outputs 0.
- Write 0x100=0x34 then ch_index=0 -> ch_freq still 0x000; write 0x101=0x12 -> ch_freq=0x234 one cycle later, clear_counter=0b00001 pulsed on each write.
- Write wave 0x045=0xA5; ack after 3 cycles -> sram_req held 3 cycles, sram_id=2, sram_a=5, we=1, no rdvalid; read back -> rddata 0xA5 at ack+1.
- Three wave reads back-to-back with ack delayed 5 cycles -> second queued, third dropped with overrun pulse; two rdvalid pulses in order.
- Register read 0x118 issued so its result lands in wave-read response cycle -> register data first, wave data next cycle.
- Assert nreset while sram_req high -> sram_req drops asynchronously, no rdvalid, busy 0, pending slot empty after release.
